// File: rtl/trng_pkg.sv
// trng_pkg: shared state encoding and constants for the TRNG bit collector.
package trng_pkg;
    localparam int SYNC_STAGES = 2;
    typedef enum logic [1:0] {IDLE, WARMUP, COLLECT, HOLD} trng_state_e;
endpackage

// File: rtl/trng_sync.sv
// trng_sync: SYNC_STAGES-flop synchroniser for the asynchronous RO output bit.
module trng_sync
    import trng_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
    assign q_o = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/trng_bit_collector.sv
// trng_bit_collector: RO sampling, von Neumann correction and word packing over valid/ready.
// Optional repetition-count health test enabled by defining TRNG_HEALTH_EN.
module trng_bit_collector
    import trng_pkg::*;
#(
    parameter int WORD_WIDTH    = 32,
    parameter int SAMPLE_DIV    = 8,
    parameter int WARMUP_CYCLES = 256,
    parameter int REP_LIMIT     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic                  raw_bit_i,
    output logic                  ro_enable_o,
    output logic [WORD_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  health_err_o
);
    localparam int DW = $clog2(SAMPLE_DIV + 1);
    localparam int WW = $clog2(WARMUP_CYCLES + 1);
    localparam int CW = $clog2(WORD_WIDTH + 1);

    if (WORD_WIDTH < 2 || SAMPLE_DIV < 1 || WARMUP_CYCLES < 1 || REP_LIMIT < 1) begin : g_param_check
        $error("trng_bit_collector: illegal parameter value");
    end

    trng_state_e           state_q, state_d;
    logic [WW-1:0]         warm_q, warm_d;
    logic [DW-1:0]         div_q, div_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  phase_q, phase_d;
    logic                  a_q, a_d;
    logic [WORD_WIDTH-1:0] sr_q, sr_d;
    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  s, tick, emit, word_done, fault;

    trng_sync u_sync (.clk_i(clk_i), .rst_ni(rst_ni), .d_i(raw_bit_i), .q_o(s));

    always_comb begin
        tick      = (state_q == COLLECT) && (div_q == DW'(SAMPLE_DIV - 1));
        emit      = tick && phase_q && (a_q != s);
        word_done = emit && (cnt_q == CW'(WORD_WIDTH - 1));
    end

    // Counters default to zero so leaving COLLECT/WARMUP discards any partial progress.
    always_comb begin
        state_d = state_q;
        warm_d  = '0;
        div_d   = '0;
        phase_d = 1'b0;
        cnt_d   = '0;
        a_d     = a_q;
        sr_d    = sr_q;
        data_d  = data_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: state_d = (enable_i && !health_err_o) ? WARMUP : IDLE;
            WARMUP: begin
                warm_d  = warm_q + WW'(1);
                state_d = !enable_i ? IDLE : (warm_q == WW'(WARMUP_CYCLES - 1)) ? COLLECT : WARMUP;
            end
            COLLECT: begin
                if (!enable_i || fault) begin
                    state_d = IDLE;
                end else begin
                    div_d   = tick ? '0 : div_q + DW'(1);
                    phase_d = phase_q ^ tick;
                    cnt_d   = emit ? cnt_q + CW'(1) : cnt_q;
                    a_d     = (tick && !phase_q) ? s : a_q;
                    sr_d    = emit ? {sr_q[WORD_WIDTH-2:0], a_q} : sr_q;
                    if (word_done) begin
                        data_d  = {sr_q[WORD_WIDTH-2:0], a_q};
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    state_d = enable_i ? COLLECT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            warm_q  <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            a_q     <= 1'b0;
            sr_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            a_q     <= a_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

`ifdef TRNG_HEALTH_EN
    localparam int RW = $clog2(REP_LIMIT + 1);
    logic [RW-1:0] run_q, run_d;
    logic          prev_q, err_q;

    // Run length survives HOLD so a stuck ring is still caught across word boundaries.
    always_comb begin
        run_d = run_q;
        if (state_q == IDLE || state_q == WARMUP)
            run_d = '0;
        else if (tick)
            run_d = (run_q != '0 && s == prev_q) ? ((run_q == RW'(REP_LIMIT)) ? run_q : run_q + RW'(1)) : RW'(1);
        fault = tick && (run_d == RW'(REP_LIMIT));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q  <= '0;
            prev_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            run_q  <= run_d;
            prev_q <= tick ? s : prev_q;
            err_q  <= enable_i && (err_q || fault);
        end
    end

    assign health_err_o = err_q;
`else
    assign fault        = 1'b0;
    assign health_err_o = 1'b0;
`endif

    assign ro_enable_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign data_o      = data_q;
    assign valid_o     = valid_q;
endmodule

// File: tb/tb_trng_bit_collector.sv
// tb_trng_bit_collector: randomized self-checking bench with a von Neumann reference model.
module tb_trng_bit_collector;
    localparam int W  = 8;
    localparam int SD = 2;
    localparam int WU = 4;
    localparam int RL = 6;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         enable_i = 1'b0;
    logic         raw_bit_i = 1'b0;
    logic         ready_i = 1'b0;
    logic         ro_enable_o, valid_o, busy_o, health_err_o;
    logic [W-1:0] data_o;
    logic [W-1:0] exp_word;
    int           n_checks = 0;
    int           n_fail = 0;

    trng_bit_collector #(
        .WORD_WIDTH(W), .SAMPLE_DIV(SD), .WARMUP_CYCLES(WU), .REP_LIMIT(RL)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .raw_bit_i(raw_bit_i),
        .ro_enable_o(ro_enable_o), .data_o(data_o), .valid_o(valid_o),
        .ready_i(ready_i), .busy_o(busy_o), .health_err_o(health_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Von Neumann over consecutive sample pairs, first emitted bit ends up as MSB.
    function automatic logic [W-1:0] vn_word(input bit s[$]);
        logic [W-1:0] w = '0;
        int n = 0;
        for (int i = 0; i + 1 < s.size() && n < W; i += 2) begin
            if (s[i] != s[i+1]) begin
                w = {w[W-2:0], 1'(s[i])};
                n++;
            end
        end
        return w;
    endfunction

    task automatic gen_word(input bit mix, output bit s[$]);
        bit a, b;
        s = {};
        for (int i = 0; i < W; i++) begin
            a = 1'($urandom);
            s.push_back(a);
            s.push_back(!a);
            if (mix && i < W - 1) begin
                b = 1'($urandom);
                s.push_back(b);
                s.push_back(b);
            end
        end
    endtask

    // Each sample is held across the sampling edge and the one after it.
    task automatic drive(input bit s[$]);
        foreach (s[i]) begin
            raw_bit_i = s[i];
            repeat (SD) step();
        end
    endtask

    task automatic wait_valid();
        int t = 0;
        while (valid_o !== 1'b1 && t < 30) begin
            step();
            t++;
        end
        n_checks++;
        if (t != 1) begin
            n_fail++;
            $display("FAIL word_latency: valid_o after %0d clocks, required 1", t);
        end
    endtask

    task automatic check_word(input string name, input bit s[$]);
        exp_word = vn_word(s);
        n_checks++;
        if (data_o !== exp_word) begin
            n_fail++;
            $display("FAIL %s: data_o=%h required %h", name, data_o, exp_word);
        end
    endtask

    task automatic start_word(input bit s[$]);
        enable_i = 1'b1;
        repeat (WU + SD - 2) step();
        drive(s);
        wait_valid();
    endtask

    task automatic resume_word(input bit s[$]);
        ready_i   = 1'b1;
        raw_bit_i = s[0];
        step();
        ready_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_drop: valid_o=%b required 0", valid_o);
        end
        repeat (SD - 1) step();
        drive(s[1:$]);
        wait_valid();
    endtask

    task automatic release_idle();
        ready_i  = 1'b1;
        enable_i = 1'b0;
        step();
        ready_i = 1'b0;
        n_checks++;
        if ({valid_o, busy_o, ro_enable_o} !== 3'b001) begin
            n_fail++;
            $display("FAIL release_idle: valid/busy/ro=%b required 001", {valid_o, busy_o, ro_enable_o});
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        n_checks++;
        if ({ro_enable_o, busy_o, valid_o, health_err_o, data_o} !== {4'b1000, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_values: ro/busy/valid/err/data=%b %h required 1000 00",
                     {ro_enable_o, busy_o, valid_o, health_err_o}, data_o);
        end
        rst_ni = 1'b1;
        for (int k = 0; k < 12; k++) begin
            raw_bit_i = 1'($urandom);
            step();
            n_checks++;
            if ({ro_enable_o, busy_o, valid_o, data_o} !== {3'b100, 8'h00}) begin
                n_fail++;
                $display("FAIL idle_after_reset: ro/busy/valid/data=%b %h required 100 00",
                         {ro_enable_o, busy_o, valid_o}, data_o);
            end
        end
    endtask

    task automatic test_fixed_word();
        bit s[$] = '{1,0, 0,1, 1,0, 0,1, 0,1, 1,0, 0,1, 1,0};
        start_word(s);
        check_word("fixed_word_model", s);
        n_checks++;
        if (data_o !== 8'hA5) begin
            n_fail++;
            $display("FAIL fixed_word: data_o=%h required a5", data_o);
        end
    endtask

    task automatic test_hold_stall();
        bit s[$];
        for (int k = 0; k < 20; k++) begin
            raw_bit_i = 1'($urandom);
            step();
            n_checks++;
            if ({valid_o, ro_enable_o, busy_o, data_o} !== {3'b101, exp_word}) begin
                n_fail++;
                $display("FAIL hold_stable: valid/ro/busy/data=%b %h required 101 %h",
                         {valid_o, ro_enable_o, busy_o}, data_o, exp_word);
            end
        end
        gen_word(1'b0, s);
        resume_word(s);
        check_word("word_after_stall", s);
    endtask

    task automatic test_invalid_pairs();
        bit s[$];
        gen_word(1'b1, s);
        resume_word(s);
        check_word("invalid_pairs", s);
        release_idle();
    endtask

    task automatic test_disable();
        bit s[$];
        gen_word(1'b0, s);
        enable_i = 1'b1;
        repeat (WU + SD - 2) step();
        drive(s[0:5]);
        step();
        enable_i = 1'b0;
        step();
        n_checks++;
        if ({busy_o, ro_enable_o, valid_o} !== 3'b010) begin
            n_fail++;
            $display("FAIL disable_idle: busy/ro/valid=%b required 010", {busy_o, ro_enable_o, valid_o});
        end
        repeat (3) step();
        enable_i = 1'b1;
        for (int k = 0; k < WU + SD - 2; k++) begin
            raw_bit_i = 1'($urandom);
            step();
            if (k == 0) begin
                n_checks++;
                if ({busy_o, ro_enable_o} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL reenable: busy/ro=%b required 10", {busy_o, ro_enable_o});
                end
            end
        end
        gen_word(1'b0, s);
        drive(s);
        wait_valid();
        check_word("word_after_reenable", s);
    endtask

    task automatic test_back_to_back();
        bit s[$];
        for (int w = 0; w < 3; w++) begin
            repeat ($urandom_range(0, 3)) begin
                raw_bit_i = 1'($urandom);
                step();
            end
            gen_word(w[0], s);
            resume_word(s);
            check_word("back_to_back", s);
        end
        release_idle();
    endtask

    task automatic test_health();
        raw_bit_i = 1'b1;
        enable_i  = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step();
            n_checks++;
`ifdef TRNG_HEALTH_EN
            if ({health_err_o, ro_enable_o, valid_o} !== ((k >= 17) ? 3'b110 : 3'b000)) begin
                n_fail++;
                $display("FAIL health_trip k=%0d: err/ro/valid=%b required %b", k,
                         {health_err_o, ro_enable_o, valid_o}, (k >= 17) ? 3'b110 : 3'b000);
            end
`else
            if ({health_err_o, ro_enable_o, valid_o} !== 3'b000) begin
                n_fail++;
                $display("FAIL constant_input k=%0d: err/ro/valid=%b required 000", k,
                         {health_err_o, ro_enable_o, valid_o});
            end
`endif
        end
        enable_i = 1'b0;
        step();
        n_checks++;
        if ({health_err_o, busy_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL health_clear: err/busy=%b required 00", {health_err_o, busy_o});
        end
        enable_i = 1'b1;
        step();
        n_checks++;
        if ({health_err_o, busy_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL health_restart: err/busy=%b required 01", {health_err_o, busy_o});
        end
        enable_i = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_fixed_word();
        test_hold_stall();
        test_invalid_pairs();
        test_disable();
        test_back_to_back();
        test_health();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
